// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, access sizes,
// request payload, lane mask and alignment checks.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH_WORDS = 1024;
  localparam int unsigned DMEM_ADDR_BITS   = 10;
  localparam int unsigned DMEM_LATENCY     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    size_e       size;
    logic        sext;
  } req_t;

  // Byte takes priority over half; neither set means a full word.
  function automatic size_e size_decode(input logic is_byte, input logic is_half);
    if (is_byte)      size_decode = SZ_BYTE;
    else if (is_half) size_decode = SZ_HALF;
    else              size_decode = SZ_WORD;
  endfunction

  // mask[3] is the most significant lane (byte offset 0, big-endian).
  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: lane_mask = 4'b1000 >> off;
      SZ_HALF: lane_mask = off[1] ? 4'b0011 : 4'b1100;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: merges store data into the old word and extracts/extends load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_sext,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_word,
  output logic [31:0] o_merged_c,
  output logic [31:0] o_load_c
);

  size_e       w_size;
  logic [3:0]  w_mask;
  logic [31:0] w_steer;
  logic [1:0]  w_shamt;
  logic [15:0] w_shifted;

  assign w_size = size_e'(i_size);
  assign w_mask = lane_mask(w_size, i_off);

  // Replicate the low-order store lanes so every candidate lane carries the data.
  always_comb begin
    w_steer = i_st_data;
    case (w_size)
      SZ_BYTE: w_steer = {4{i_st_data[7:0]}};
      SZ_HALF: w_steer = {2{i_st_data[15:0]}};
      default: w_steer = i_st_data;
    endcase
  end

  always_comb begin
    o_merged_c = i_word;
    for (int k = 0; k < 4; k++) begin
      if (w_mask[k]) o_merged_c[8*k +: 8] = w_steer[8*k +: 8];
    end
  end

  always_comb begin
    w_shamt = 2'd0;
    case (w_size)
      SZ_BYTE: w_shamt = 2'd3 - i_off;
      SZ_HALF: w_shamt = i_off[1] ? 2'd0 : 2'd2;
      default: w_shamt = 2'd0;
    endcase
  end

  assign w_shifted = 16'(i_word >> {w_shamt, 3'b000});

  always_comb begin
    o_load_c = i_word;
    case (w_size)
      SZ_BYTE: o_load_c = {{24{i_sext & w_shifted[7]}},  w_shifted[7:0]};
      SZ_HALF: o_load_c = {{16{i_sext & w_shifted[15]}}, w_shifted[15:0]};
      default: o_load_c = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one request at a time over valid/ready, word RAM with
// big-endian byte lanes, registered response pulse with load data or misalignment error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DMEM_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic        req_half,
  input  logic        req_sext,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int unsigned ADDR_BITS = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  req_t                   r_req;
  logic [31:0]            r_mem [DEPTH_WORDS];

  req_t                   w_in_req;
  req_t                   w_cur;
  logic [1:0]             w_off;
  logic [ADDR_BITS-1:0]   w_idx;
  logic                   w_mis;
  logic                   w_commit;
  logic                   w_wr_en;
  logic [31:0]            w_old;
  logic [31:0]            w_merged;
  logic [31:0]            w_load;
  logic                   w_unused_addr;

  always_comb begin
    w_in_req.addr = req_addr;
    w_in_req.data = req_data;
    w_in_req.we   = req_we;
    w_in_req.size = size_decode(req_byte, req_half);
    w_in_req.sext = req_sext;
  end

  // With single-cycle latency the access happens on the accept edge, straight from the inputs.
  assign w_cur         = (LATENCY == 1) ? w_in_req : r_req;
  assign w_off         = w_cur.addr[1:0];
  assign w_idx         = w_cur.addr[ADDR_BITS+1:2];
  assign w_unused_addr = ^w_cur.addr[31:ADDR_BITS+2];
  assign w_mis         = misaligned(w_cur.size, w_off);
  assign w_old         = r_mem[w_idx];

  assign w_commit = ((r_state == IDLE) && req_valid && (LATENCY == 1)) ||
                    ((r_state == WAIT) && (r_cnt == CNT_W'(1)));
  assign w_wr_en  = w_commit && w_cur.we && !w_mis;

  dmem_lane_align u_align (
    .i_size     (w_cur.size),
    .i_off      (w_off),
    .i_sext     (w_cur.sext),
    .i_st_data  (w_cur.data),
    .i_word     (w_old),
    .o_merged_c (w_merged),
    .o_load_c   (w_load)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_req      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_req     <= w_in_req;
            r_cnt     <= CNT_W'(LATENCY - 1);
            req_ready <= 1'b0;
            r_state   <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == CNT_W'(1)) r_state <= RESP;
          else                    r_cnt   <= r_cnt - CNT_W'(1);
        end
        RESP: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase

      if (w_commit) begin
        resp_valid <= 1'b1;
        resp_err   <= w_mis;
        resp_data  <= (w_mis || w_cur.we) ? 32'h0 : w_load;
      end
    end
  end

  // Storage is never cleared; reset suppresses a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) r_mem[w_idx] <= w_merged;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of load/store vectors plus reset and throughput sequences.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_we;
  logic        req_byte;
  logic        req_half;
  logic        req_sext;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_we     (req_we),
    .req_byte   (req_byte),
    .req_half   (req_half),
    .req_sext   (req_sext),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic        byt;
    logic        half;
    logic        sext;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    req_addr = v.addr;
    req_data = v.data;
    req_we   = v.we;
    req_byte = v.byt;
    req_half = v.half;
    req_sext = v.sext;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("%s ready", tag), 32'(req_ready), 32'd1);
  endtask

  // Issue one request and check latency, pulse width, data, error and hold behaviour.
  task automatic do_req(input vec_t v, input string tag);
    int lat;
    bit seen;
    wait_ready(tag);
    drive(v);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (lat <= LAT + 4) begin
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    check($sformatf("%s latency", tag), seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(LAT));
    if (seen) begin
      check($sformatf("%s data", tag), resp_data, v.exp_data);
      check($sformatf("%s err", tag), 32'(resp_err), 32'(v.exp_err));
      check($sformatf("%s busy", tag), 32'(req_ready), 32'd0);
      tick();
      check($sformatf("%s pulse", tag), 32'(resp_valid), 32'd0);
      check($sformatf("%s hold", tag), resp_data, v.exp_data);
    end
  endtask

  initial begin
    vec_t v;
    int   pulses[$];
    int   npulse;

    vecs[0]  = '{32'h10,   32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{32'h10,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{32'h10,   32'h11223344, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3]  = '{32'h11,   32'h000000AA, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[4]  = '{32'h10,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h11AA_3344, 1'b0};
    vecs[5]  = '{32'h11,   32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFAA, 1'b0};
    vecs[6]  = '{32'h11,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00AA, 1'b0};
    vecs[7]  = '{32'h12,   32'h00008001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
    vecs[8]  = '{32'h10,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h11AA_8001, 1'b0};
    vecs[9]  = '{32'h12,   32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_8001, 1'b0};
    vecs[10] = '{32'h13,   32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
    vecs[11] = '{32'h10,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h11AA_8001, 1'b0};
    vecs[12] = '{32'h11,   32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[13] = '{32'h1004, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[14] = '{32'h4,    32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b0};
    vecs[15] = '{32'h10,   32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_11AA, 1'b0};
    vecs[16] = '{32'h13,   32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b0};
    vecs[17] = '{32'h12,   32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b0};
    vecs[18] = '{32'h20,   32'h55667788, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[19] = '{32'h23,   32'h123456C3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[20] = '{32'h20,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h5566_77C3, 1'b0};
    vecs[21] = '{32'h22,   32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_77C3, 1'b0};
    vecs[22] = '{32'h10,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h11AA_8001, 1'b0};
    vecs[23] = '{32'h21,   32'h0000FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[24] = '{32'h20,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h5566_77C3, 1'b0};
    vecs[25] = '{32'h11,   32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_00AA, 1'b0};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    req_we    = 1'b0;
    req_byte  = 1'b0;
    req_half  = 1'b0;
    req_sext  = 1'b0;
    repeat (3) tick();
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst valid", 32'(resp_valid), 32'd0);
    check("rst data", resp_data, 32'h0);
    check("rst err", 32'(resp_err), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 26; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    // Throughput: req_valid held high, responses one per LAT+1 cycles.
    wait_ready("thru");
    v = '{32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
    drive(v);
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (resp_valid) begin
        pulses.push_back(c);
        check($sformatf("thru data%0d", pulses.size()), resp_data, 32'h11AA_8001);
      end
      if (pulses.size() == 2) break;
    end
    req_valid = 1'b0;
    npulse = pulses.size();
    check("thru count", 32'(npulse), 32'd2);
    if (npulse == 2) check("thru interval", 32'(pulses[1] - pulses[0]), 32'(LAT + 1));
    tick();

    // Reset while the store sits in WAIT: no write, no response pulse.
    wait_ready("rstwait");
    v = '{32'h20, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
    drive(v);
    req_valid = 1'b1;
    tick();
    check("rstwait busy", 32'(req_ready), 32'd0);
    reset = 1'b1;
    tick();
    check("rstwait ready", 32'(req_ready), 32'd1);
    check("rstwait valid", 32'(resp_valid), 32'd0);
    check("rstwait data", resp_data, 32'h0);
    reset     = 1'b0;
    req_valid = 1'b0;
    npulse    = 0;
    repeat (4) begin
      tick();
      if (resp_valid) npulse++;
    end
    check("rstwait nopulse", 32'(npulse), 32'd0);
    do_req('{32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5566_77C3, 1'b0}, "rstwait load");

    // Inputs changed and held while busy must be ignored.
    wait_ready("ign");
    v = '{32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
    drive(v);
    req_valid = 1'b1;
    tick();
    v = '{32'h20, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
    drive(v);
    tick();
    check("ign valid", 32'(resp_valid), 32'd1);
    check("ign data", resp_data, 32'h5566_77C3);
    tick();
    req_valid = 1'b0;
    check("ign idle valid", 32'(resp_valid), 32'd0);
    check("ign idle ready", 32'(req_ready), 32'd1);
    tick();
    check("ign nopulse", 32'(resp_valid), 32'd0);
    do_req('{32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5566_77C3, 1'b0}, "ign load");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
